// File: rtl/adder_pkg.sv
// Shared configuration helpers for the pipelined adder/subtractor.
// Holds the operation encoding and the slice-geometry functions used at elaboration.
package adder_pkg;

   localparam logic OP_SUB = 1'b1;

   function automatic int unsigned slice_width(input int unsigned width,
                                               input int unsigned stages);
      return (stages == 0) ? width : width / stages;
   endfunction

   function automatic bit cfg_ok(input int unsigned width, input int unsigned stages);
      return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
   endfunction

endpackage

// File: rtl/adder_slice.sv
// Combinational SLICE-bit ripple adder built from full-adder cells.
// Also exposes the carry into its top bit so the last slice can form signed overflow.
module adder_slice #(
   parameter int unsigned SLICE = 4
) (
   input  logic [SLICE-1:0] a,
   input  logic [SLICE-1:0] b,
   input  logic             cin,
   output logic [SLICE-1:0] sum,
   output logic             cout,
   output logic             c_msb_in
);

   logic [SLICE:0] carry_c;

   always_comb begin
      carry_c    = '0;
      sum        = '0;
      carry_c[0] = cin;
      for (int unsigned i = 0; i < SLICE; i++) begin
         sum[i]         = a[i] ^ b[i] ^ carry_c[i];
         carry_c[i + 1] = (a[i] & b[i]) | (carry_c[i] & (a[i] ^ b[i]));
      end
   end

   assign cout     = carry_c[SLICE];
   assign c_msb_in = carry_c[SLICE - 1];

endmodule

// File: rtl/pipelined_add_sub.sv
// WIDTH-bit add/subtract split into STAGES carry-registered slices under a valid/ready handshake.
// The whole pipe advances or stalls together; results emerge STAGES accepted cycles later.
module pipelined_add_sub
   import adder_pkg::*;
#(
   parameter int unsigned WIDTH  = 16,
   parameter int unsigned STAGES = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Cin,
   input  logic             Sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] Sum,
   output logic             Carry,
   output logic             Overflow
);

   localparam int unsigned SLICE = slice_width(WIDTH, STAGES);
   localparam int unsigned LAST  = STAGES - 1;

   if (!cfg_ok(WIDTH, STAGES)) begin : g_bad_cfg
      $error("pipelined_add_sub: WIDTH must be a multiple of STAGES and 1 <= STAGES <= WIDTH");
   end

   // Per level: w holds finished low-slice sums with still-pending A slices above them,
   // bw holds the (possibly inverted) B operand, c the carry out of the slice just added.
   logic [STAGES-1:0] v_q, v_d, src_v;
   logic [STAGES-1:0] c_q, c_d, src_c;
   logic [WIDTH-1:0]  w_q   [STAGES];
   logic [WIDTH-1:0]  w_d   [STAGES];
   logic [WIDTH-1:0]  src_w [STAGES];
   logic [WIDTH-1:0]  bw_q  [STAGES];
   logic [WIDTH-1:0]  bw_d  [STAGES];
   logic [WIDTH-1:0]  src_bw[STAGES];
   logic [SLICE-1:0]  s_sum [STAGES];
   logic [STAGES-1:0] s_cout;
   logic              s_cmsb[STAGES];
   logic              ov_q, ov_d;
   logic              adv_c;

   assign adv_c    = !v_q[LAST] || out_ready;
   assign in_ready = adv_c;

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      if (k == 0) begin : g_head
         assign src_v[k]  = in_valid;
         assign src_w[k]  = A;
         assign src_bw[k] = (Sub == OP_SUB) ? ~B : B;
         assign src_c[k]  = (Sub == OP_SUB) ? 1'b1 : Cin;
      end else begin : g_tail
         assign src_v[k]  = v_q[k-1];
         assign src_w[k]  = w_q[k-1];
         assign src_bw[k] = bw_q[k-1];
         assign src_c[k]  = c_q[k-1];
      end

      adder_slice #(.SLICE(SLICE)) u_slice (
         .a        (src_w[k][k*SLICE +: SLICE]),
         .b        (src_bw[k][k*SLICE +: SLICE]),
         .cin      (src_c[k]),
         .sum      (s_sum[k]),
         .cout     (s_cout[k]),
         .c_msb_in (s_cmsb[k])
      );
   end

   // Data registers only load on a valid beat so the output holds across bubbles.
   always_comb begin
      v_d  = v_q;
      c_d  = c_q;
      ov_d = ov_q;
      for (int unsigned k = 0; k < STAGES; k++) begin
         w_d[k]  = w_q[k];
         bw_d[k] = bw_q[k];
      end
      if (adv_c) begin
         v_d = src_v;
         for (int unsigned k = 0; k < STAGES; k++) begin
            if (src_v[k]) begin
               w_d[k]                     = src_w[k];
               w_d[k][k*SLICE +: SLICE]   = s_sum[k];
               bw_d[k]                    = src_bw[k];
               c_d[k]                     = s_cout[k];
            end
         end
         if (src_v[LAST]) begin
            ov_d = s_cout[LAST] ^ s_cmsb[LAST];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v_q  <= '0;
         c_q  <= '0;
         ov_q <= 1'b0;
         for (int unsigned k = 0; k < STAGES; k++) begin
            w_q[k]  <= '0;
            bw_q[k] <= '0;
         end
      end else begin
         v_q  <= v_d;
         c_q  <= c_d;
         ov_q <= ov_d;
         for (int unsigned k = 0; k < STAGES; k++) begin
            w_q[k]  <= w_d[k];
            bw_q[k] <= bw_d[k];
         end
      end
   end

   assign out_valid = v_q[LAST];
   assign Sum       = w_q[LAST];
   assign Carry     = c_q[LAST];
   assign Overflow  = ov_q;

endmodule

// File: tb/tb_pipelined_add_sub.sv
// Bench for pipelined_add_sub: directed cases on a 16/4 instance, then random streams on 8/1, 8/8, 32/4.
// Expected results come from plain integer arithmetic on accepted beats, shifted through a stall-aware slot list.
module tb_pipelined_add_sub;

   typedef struct { bit v; longint sum; bit c; bit o; int acc; } exp_t;
   typedef struct { longint sum; bit c; bit o; int acc; int vis; } dlv_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        iv_v [4];
   logic        or_v [4];
   logic        cin_v[4];
   logic        sub_v[4];
   logic [31:0] a_v  [4];
   logic [31:0] b_v  [4];
   logic        ir_v [4];
   logic        ov_v [4];
   logic        c_v  [4];
   logic        o_v  [4];
   logic [31:0] sum_v[4];
   logic [15:0] s0;
   logic [7:0]  s1, s2;
   logic [31:0] s3;

   int   n_assert = 0;
   int   n_fail   = 0;
   int   cyc      = 0;
   int   n_acc    = 0;
   exp_t slot[8];
   dlv_t dq[$];

   pipelined_add_sub #(.WIDTH(16), .STAGES(4)) u_d0 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv_v[0]), .in_ready(ir_v[0]),
      .A(a_v[0][15:0]), .B(b_v[0][15:0]), .Cin(cin_v[0]), .Sub(sub_v[0]),
      .out_valid(ov_v[0]), .out_ready(or_v[0]), .Sum(s0), .Carry(c_v[0]), .Overflow(o_v[0]));
   pipelined_add_sub #(.WIDTH(8), .STAGES(1)) u_d1 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv_v[1]), .in_ready(ir_v[1]),
      .A(a_v[1][7:0]), .B(b_v[1][7:0]), .Cin(cin_v[1]), .Sub(sub_v[1]),
      .out_valid(ov_v[1]), .out_ready(or_v[1]), .Sum(s1), .Carry(c_v[1]), .Overflow(o_v[1]));
   pipelined_add_sub #(.WIDTH(8), .STAGES(8)) u_d2 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv_v[2]), .in_ready(ir_v[2]),
      .A(a_v[2][7:0]), .B(b_v[2][7:0]), .Cin(cin_v[2]), .Sub(sub_v[2]),
      .out_valid(ov_v[2]), .out_ready(or_v[2]), .Sum(s2), .Carry(c_v[2]), .Overflow(o_v[2]));
   pipelined_add_sub #(.WIDTH(32), .STAGES(4)) u_d3 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv_v[3]), .in_ready(ir_v[3]),
      .A(a_v[3]), .B(b_v[3]), .Cin(cin_v[3]), .Sub(sub_v[3]),
      .out_valid(ov_v[3]), .out_ready(or_v[3]), .Sum(s3), .Carry(c_v[3]), .Overflow(o_v[3]));

   assign sum_v[0] = 32'(s0);
   assign sum_v[1] = 32'(s1);
   assign sum_v[2] = 32'(s2);
   assign sum_v[3] = s3;

   function automatic int wd(input int k);
      case (k)
         0:       return 16;
         1, 2:    return 8;
         default: return 32;
      endcase
   endfunction

   function automatic int sg(input int k);
      case (k)
         0:       return 4;
         1:       return 1;
         2:       return 8;
         default: return 4;
      endcase
   endfunction

   // Reference: plain unsigned/signed arithmetic on whole operands.
   function automatic exp_t ref_op(input int w, input longint a, input longint b,
                                   input bit cin, input bit sub, input int acc);
      exp_t   r;
      longint lim, sa, sb, sr, t;
      lim = longint'(1) << (w - 1);
      sa  = (a >= lim) ? a - 2 * lim : a;
      sb  = (b >= lim) ? b - 2 * lim : b;
      if (sub) begin
         r.sum = (a - b) & (2 * lim - 1);
         r.c   = (a >= b);
         sr    = sa - sb;
      end else begin
         t     = a + b + longint'(cin);
         r.sum = t & (2 * lim - 1);
         r.c   = (t >= 2 * lim);
         sr    = sa + sb + longint'(cin);
      end
      r.o   = (sr >= lim) || (sr < -lim);
      r.v   = 1'b1;
      r.acc = acc;
      return r;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_assert++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic drive(input int k, input bit v, input longint a, input longint b,
                        input bit cin, input bit sub, input bit ordy);
      iv_v[k]  = v;
      a_v[k]   = 32'(a);
      b_v[k]   = 32'(b);
      cin_v[k] = cin;
      sub_v[k] = sub;
      or_v[k]  = ordy;
   endtask

   task automatic clear_model();
      for (int i = 0; i < 8; i++) slot[i] = '{v: 1'b0, sum: 0, c: 1'b0, o: 1'b0, acc: 0};
   endtask

   // One clock: check outputs against the model, then advance the model on the edge.
   task automatic tick(input int k);
      exp_t        e, nb;
      int          st;
      logic [31:0] osum;
      logic        oc, oo;
      st = sg(k);
      #1;
      e = slot[st-1];
      chk("out_valid", ov_v[k], e.v);
      chk("in_ready", ir_v[k], !e.v || or_v[k]);
      osum = sum_v[k];
      oc   = c_v[k];
      oo   = o_v[k];
      if (e.v) begin
         chk("sum", osum, e.sum);
         chk("carry", oc, e.c);
         chk("overflow", oo, e.o);
      end
      @(posedge clk);
      if (!e.v || or_v[k]) begin
         if (e.v) dq.push_back('{sum: longint'(osum), c: oc, o: oo, acc: e.acc, vis: cyc});
         for (int i = st - 1; i > 0; i--) slot[i] = slot[i-1];
         nb = '{v: 1'b0, sum: 0, c: 1'b0, o: 1'b0, acc: 0};
         if (iv_v[k]) begin
            nb = ref_op(wd(k), longint'(a_v[k]), longint'(b_v[k]), cin_v[k], sub_v[k], cyc);
            n_acc++;
         end
         slot[0] = nb;
      end
      cyc++;
      @(negedge clk);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int     idx;
      bit     stall;
      longint m;

      for (int k = 0; k < 4; k++) drive(k, 1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
      or_v[0] = 1'b0;
      clear_model();
      rst_n = 1'b0;
      #12;
      chk("rst_out_valid", ov_v[0], 1'b0);
      chk("rst_in_ready", ir_v[0], 1'b1);
      chk("rst_sum", sum_v[0], 64'h0);
      chk("rst_carry", c_v[0], 1'b0);
      chk("rst_overflow", o_v[0], 1'b0);
      @(negedge clk);
      rst_n = 1'b1;

      // Single add with full carry-out.
      drive(0, 1'b1, 'hFFFF, 'h0001, 1'b0, 1'b0, 1'b1);
      tick(0);
      drive(0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
      repeat (5) tick(0);
      chk("add_count", dq.size(), 1);
      if (dq.size() == 1) begin
         chk("add_sum", dq[0].sum, 64'h0);
         chk("add_carry", dq[0].c, 1'b1);
         chk("add_overflow", dq[0].o, 1'b0);
         chk("add_latency", dq[0].vis - dq[0].acc, 4);
      end
      dq.delete();

      // Subtract with borrow (Cin ignored), then signed overflow.
      drive(0, 1'b1, 'h0003, 'h0005, 1'b1, 1'b1, 1'b1);
      tick(0);
      drive(0, 1'b1, 'h8000, 'h0001, 1'b0, 1'b1, 1'b1);
      tick(0);
      drive(0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
      repeat (5) tick(0);
      chk("sub_count", dq.size(), 2);
      if (dq.size() == 2) begin
         chk("sub_borrow_sum", dq[0].sum, 64'hFFFE);
         chk("sub_borrow_carry", dq[0].c, 1'b0);
         chk("sub_borrow_ovf", dq[0].o, 1'b0);
         chk("sub_ovf_sum", dq[1].sum, 64'h7FFF);
         chk("sub_ovf_carry", dq[1].c, 1'b1);
         chk("sub_ovf_ovf", dq[1].o, 1'b1);
      end
      dq.delete();

      // Back-to-back streaming.
      for (int i = 0; i < 8; i++) begin
         drive(0, 1'b1, i, 3 * i, 1'b0, 1'b0, 1'b1);
         tick(0);
      end
      drive(0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
      repeat (6) tick(0);
      chk("stream_count", dq.size(), 8);
      if (dq.size() == 8) begin
         for (int i = 0; i < 8; i++) begin
            chk("stream_sum", dq[i].sum, 4 * i);
            chk("stream_latency", dq[i].vis - dq[i].acc, 4);
            chk("stream_gapless", dq[i].vis, dq[0].vis + i);
         end
      end
      dq.delete();

      // Backpressure: three stall cycles once the first result is visible.
      idx = 0;
      for (int t = 0; t < 30 && dq.size() < 6; t++) begin
         stall = (t >= 4) && (t < 7);
         drive(0, idx < 6, 100 * idx, 7, 1'b0, 1'b0, !stall);
         if (stall) begin
            #1;
            chk("bp_in_ready", ir_v[0], 1'b0);
            chk("bp_hold_valid", ov_v[0], 1'b1);
            chk("bp_hold_sum", sum_v[0], 64'd7);
         end
         if (idx < 6 && (!slot[3].v || !stall)) idx++;
         tick(0);
      end
      chk("bp_count", dq.size(), 6);
      if (dq.size() == 6) begin
         for (int i = 0; i < 6; i++) chk("bp_order", dq[i].sum, 100 * i + 7);
      end
      dq.delete();

      // Asynchronous reset while a result is stalled at the output.
      for (int i = 0; i < 3; i++) begin
         drive(0, 1'b1, 10 + i, 1, 1'b0, 1'b0, 1'b0);
         tick(0);
      end
      drive(0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
      tick(0);
      chk("pre_rst_valid", ov_v[0], 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", ov_v[0], 1'b0);
      chk("mid_rst_sum", sum_v[0], 64'h0);
      clear_model();
      @(negedge clk);
      rst_n = 1'b1;
      drive(0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
      repeat (6) tick(0);
      drive(0, 1'b1, 1, 2, 1'b0, 1'b0, 1'b1);
      tick(0);
      drive(0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
      repeat (5) tick(0);
      chk("post_rst_count", dq.size(), 1);
      if (dq.size() == 1) chk("post_rst_sum", dq[0].sum, 3);
      dq.delete();

      // Random sweep over the other geometries with random backpressure.
      for (int k = 1; k < 4; k++) begin
         clear_model();
         dq.delete();
         n_acc = 0;
         m = (longint'(1) << wd(k)) - 1;
         for (int t = 0; t < 300; t++) begin
            drive(k, ($urandom % 10) < 7, longint'($urandom) & m, longint'($urandom) & m,
                  1'($urandom % 2), 1'($urandom % 2), ($urandom % 10) < 7);
            tick(k);
         end
         drive(k, 1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
         repeat (sg(k) + 2) tick(k);
         chk("sweep_count", dq.size(), n_acc);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
